// File: rtl/player_hit_flash.sv
// rtl/player_hit_flash.sv - hit invulnerability window with frame-paced blink of the player sprite
module player_hit_flash #(
   parameter int FLASH_FRAMES = 60,
   parameter int BLINK_FRAMES = 4
) (
   input  logic clk,
   input  logic resetN,
   input  logic startOfFrame,
   input  logic hit,
   input  logic clear,
   output logic invert_player,
   output logic invulnerable,
   output logic flash_done
);

   typedef enum logic {IDLE, FLASH} state_t;

   // 9-bit limits so that a counter at 255 plus one compares without wrapping
   localparam logic [8:0] FLASH_LIM = 9'(FLASH_FRAMES);
   localparam logic [8:0] BLINK_LIM = 9'(BLINK_FRAMES);

   state_t     state, state_nxt;
   logic [7:0] frame_cnt, frame_nxt;
   logic [7:0] blink_cnt, blink_nxt;
   logic       invert_nxt, invul_nxt, done_nxt;
   logic [8:0] frame_inc, blink_inc;

   assign frame_inc = {1'b0, frame_cnt} + 9'd1;
   assign blink_inc = {1'b0, blink_cnt} + 9'd1;

   // State, counters and all outputs are registered; reset aborts any window silently
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state         <= IDLE;
         frame_cnt     <= 8'd0;
         blink_cnt     <= 8'd0;
         invert_player <= 1'b0;
         invulnerable  <= 1'b0;
         flash_done    <= 1'b0;
      end else begin
         state         <= state_nxt;
         frame_cnt     <= frame_nxt;
         blink_cnt     <= blink_nxt;
         invert_player <= invert_nxt;
         invulnerable  <= invul_nxt;
         flash_done    <= done_nxt;
      end
   end

   // Next-state logic: clear beats hit, hit (IDLE only) beats frame pacing
   always_comb begin
      state_nxt  = state;
      frame_nxt  = frame_cnt;
      blink_nxt  = blink_cnt;
      invert_nxt = invert_player;
      invul_nxt  = invulnerable;
      done_nxt   = 1'b0;
      if (clear) begin
         state_nxt  = IDLE;
         frame_nxt  = 8'd0;
         blink_nxt  = 8'd0;
         invert_nxt = 1'b0;
         invul_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               invert_nxt = 1'b0;
               invul_nxt  = 1'b0;
               // A frame pulse coinciding with the hit is not counted
               if (hit) begin
                  state_nxt  = FLASH;
                  frame_nxt  = 8'd0;
                  blink_nxt  = 8'd0;
                  invert_nxt = 1'b1;
                  invul_nxt  = 1'b1;
               end
            end
            FLASH: begin
               if (startOfFrame) begin
                  if (frame_inc == FLASH_LIM) begin
                     state_nxt  = IDLE;
                     frame_nxt  = 8'd0;
                     blink_nxt  = 8'd0;
                     invert_nxt = 1'b0;
                     invul_nxt  = 1'b0;
                     done_nxt   = 1'b1;
                  end else begin
                     frame_nxt = frame_inc[7:0];
                     if (blink_inc == BLINK_LIM) begin
                        blink_nxt  = 8'd0;
                        invert_nxt = ~invert_player;
                     end else begin
                        blink_nxt = blink_inc[7:0];
                     end
                  end
               end
            end
            default: begin
               state_nxt  = IDLE;
               frame_nxt  = 8'd0;
               blink_nxt  = 8'd0;
               invert_nxt = 1'b0;
               invul_nxt  = 1'b0;
            end
         endcase
      end
   end

endmodule
